// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_pkg
// Description : Shared defaults and helpers for the dff_pipe valid/ready
//               register pipeline (dff_pipe, dff_pipe_stage).
// Revision    : 1.0 - initial release
// ============================================================================
package dff_pipe_pkg;

    // Default data bits per stage and default number of register stages.
    localparam int DFF_PIPE_WIDTH_DEF = 8;
    localparam int DFF_PIPE_DEPTH_DEF = 4;

    // Width of an occupancy counter able to hold every value 0..depth.
    function automatic int dff_pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : dff_pipe_pkg
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_stage
// Description : One pipeline slot: a valid bit plus a data word, both cleared
//               by an asynchronous active-low reset. When en_i is high the
//               valid bit follows vld_i; the data word is captured only when
//               the incoming valid is high, so a bubble never overwrites data.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q;
    logic [WIDTH-1:0] dat_q;

    // Slot register: clear on reset, load on enable, data only with valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (en_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                dat_q <= dat_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule : dff_pipe_stage
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe
// Description : DEPTH-stage valid/ready register pipeline. Each stage is ready
//               when it is empty or its downstream neighbour is ready, so
//               bubbles collapse and a full pipe still streams one beat per
//               cycle when out_ready is high. Ready is purely combinational.
//               Optional synchronous flush is compiled in when the macro
//               DFF_PIPE_FLUSH_EN is defined; otherwise no flush port exists.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF,
    parameter int DEPTH = DFF_PIPE_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic                               flush,
`endif
    output logic [dff_pipe_cnt_w(DEPTH)-1:0]   count
);

    localparam int CNT_W = dff_pipe_cnt_w(DEPTH);

    // Stage state as seen by the rest of the pipe.
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Per-stage load controls; rdy[DEPTH] is the downstream ready.
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] ld_en;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic             clr;
    logic [CNT_W-1:0] cnt_d;

`ifdef DFF_PIPE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Ready chain from the output end back to the input, plus stage inputs.
    // A clear enables every stage with an invalid beat, which drops all
    // valids while leaving data words untouched.
    always_comb begin
        rdy   = '0;
        ld_en = '0;
        vld_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dat_d[i] = '0;
        end

        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !vld_q[i] || rdy[i + 1];
        end

        for (int i = 0; i < DEPTH; i++) begin
            ld_en[i] = rdy[i] || clr;
            if (i == 0) begin
                vld_d[i] = in_valid && !clr;
                dat_d[i] = in_data;
            end else begin
                vld_d[i] = vld_q[i - 1] && !clr;
                dat_d[i] = dat_q[i - 1];
            end
        end
    end

    // Register stages, input side first.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            dff_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (clk),
                .rstn  (rstn),
                .en_i  (ld_en[gi]),
                .vld_i (vld_d[gi]),
                .dat_i (dat_d[gi]),
                .vld_o (vld_q[gi]),
                .dat_o (dat_q[gi])
            );
        end
    endgenerate

    // Occupancy: number of stages currently holding a valid beat.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(vld_q[i]);
        end
    end

    assign count     = cnt_d;
    assign in_ready  = rdy[0] && !clr;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule : dff_pipe
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_pipe
// Description : Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4). The
//               reference keeps the in-flight beats as a queue with a stage
//               position per beat; a beat advances when the output accepts or
//               a gap exists ahead of it. Build with DFF_PIPE_FLUSH_EN to
//               exercise flush as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             flush_s;

    always #5 clk = ~clk;

    dff_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DFF_PIPE_FLUSH_EN
        .flush     (flush_s),
`endif
        .count     (count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference: beats in arrival order (index 0 = oldest) with stage index.
    logic [WIDTH-1:0] m_dat [$];
    int               m_pos [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The input side can take a beat if downstream accepts or any stage is empty.
    function automatic logic exp_in_ready();
        if (!rstn)   return 1'b1;
        if (flush_s) return 1'b0;
        return out_ready || (m_pos.size() < DEPTH);
    endfunction

    task automatic model_clear();
        m_dat.delete();
        m_pos.delete();
    endtask

    // Advance the reference by one clock edge using pre-edge inputs/state.
    task automatic model_step(input logic v, input logic [WIDTH-1:0] d,
                              input logic o, input logic fl);
        int   n;
        logic acc;
        logic pop;
        if (!rstn || fl) begin
            model_clear();
            return;
        end
        n   = m_pos.size();
        acc = v && (o || n < DEPTH);
        pop = (n > 0) && (m_pos[0] == DEPTH - 1) && o;
        // Beat j has j beats ahead of it; it moves if there is room ahead.
        for (int j = 0; j < n; j++) begin
            if (m_pos[j] < DEPTH - 1 && (o || j < DEPTH - 1 - m_pos[j])) begin
                m_pos[j] = m_pos[j] + 1;
            end
        end
        if (pop) begin
            void'(m_dat.pop_front());
            void'(m_pos.pop_front());
        end
        if (acc) begin
            m_dat.push_back(d);
            m_pos.push_back(0);
        end
    endtask

    task automatic check_outputs();
        logic ov;
        ov = (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
        check("out_valid", out_valid, ov);
        check("count", count, m_pos.size());
        if (!rstn) begin
            check("rst_out_data", out_data, 0);
        end else if (ov) begin
            check("out_data", out_data, m_dat[0]);
        end
    endtask

    // One clock: drive, check ready, take the edge, check registered outputs.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic o, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        flush_s   = fl;
        #1;
        check("in_ready", in_ready, exp_in_ready());
        @(posedge clk);
        model_step(v, d, o, fl);
        cyc++;
        #1;
        check_outputs();
    endtask

    initial begin
        int hs_edge;
        int first_ov;
        int last_ov;
        int ov_cnt;
        logic fl;

        // Reset held with an offered beat: everything stays cleared.
        rstn      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        flush_s   = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_count", count, 0);
        check("rst_async_data", out_data, 0);
        check("rst_async_ready", in_ready, 1);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        rstn = 1'b1;

        // Streaming 01..08 with out_ready held high.
        hs_edge  = -1;
        first_ov = -1;
        last_ov  = -1;
        ov_cnt   = 0;
        for (int n = 0; n < 16; n++) begin
            cycle(n < 8, WIDTH'(n + 1), 1'b1, 1'b0);
            if (n == 0) hs_edge = cyc;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                ov_cnt++;
            end
        end
        // Cycles from the handshake cycle to the first out_valid cycle.
        check("stream_latency", first_ov - hs_edge + 1, DEPTH);
        check("stream_beats", ov_cnt, 8);
        check("stream_no_gaps", last_ov - first_ov + 1, 8);

        // Backpressure: five offers into a stalled four-stage pipe.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        end
        check("bp_count_full", count, DEPTH);
        in_valid  = 1'b1;
        in_data   = 8'h05;
        out_ready = 1'b0;
        #1;
        check("bp_full_ready", in_ready, 0);
        check("bp_head_data", out_data, 8'h01);
        cycle(1'b1, 8'h05, 1'b1, 1'b0);
        check("bp_count_hold", count, DEPTH);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Bubble collapse under a stalled output.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_count", count, 2);
        check("bubble_head", out_data, 8'h11);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset pulsed between edges while three beats are in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("midrst_pre_count", count, 3);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_ready", in_ready, 1);
        model_clear();
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef DFF_PIPE_FLUSH_EN
        // Flush a full pipe while a new beat is offered.
        for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0);
        check("flush_pre_count", count, DEPTH);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif

        // Randomised traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            fl = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
            fl = ($urandom_range(0, 31) == 0);
`endif
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom),
                  (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  fl);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("final_empty", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dff_pipe
`default_nettype wire

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  pipe accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream data.
REQ-008 out_valid  output  1  stage DEPTH-1 holds valid data.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  WIDTH  data of stage DEPTH-1.
REQ-011 count  output  $clog2(DEPTH+1)  number of stages currently valid.
REQ-012 flush  input  1  synchronous clear of all stages; present only when DFF_PIPE_FLUSH_EN is defined.

Function
REQ-013 Each stage i SHALL hold vld[i] and dat[i]; stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage ready SHALL be rdy[i] = !vld[i] || rdy[i+1], with rdy[DEPTH] = out_ready; in_ready = rdy[0] (combinational, no registered ready).
REQ-015 Stage i SHALL load from stage i-1 (or from in_valid/in_data for i=0) when rdy[i] is 1; vld[i] then takes the upstream valid, dat[i] takes upstream data only when the upstream valid is 1.
REQ-016 When rdy[i] is 0, stage i SHALL hold vld[i] and dat[i] unchanged.
REQ-017 Transfer occurs on valid&&ready at each boundary; no beat SHALL be lost, duplicated or reordered.
REQ-018 Latency with out_ready held 1 SHALL be exactly DEPTH cycles from input handshake to out_valid; throughput one beat per cycle.
REQ-019 Full condition (all vld=1, out_ready=0) SHALL drive in_ready=0; simultaneous out_ready=1 on full SHALL make in_ready=1 the same cycle and accept a new beat.
REQ-020 Bubbles SHALL collapse: an empty stage accepts even while downstream is stalled.
REQ-021 count SHALL equal the popcount of vld[] after each edge; range 0..DEPTH.
REQ-022 DEPTH=1 SHALL behave as a single enabled register with valid/ready.

Reset
REQ-023 rstn=0 SHALL immediately clear all vld[] and dat[] to 0, independent of clk.
REQ-024 During reset out_valid=0, out_data=0, count=0; in_ready SHALL read 1.
REQ-025 Reset asserted mid-transfer SHALL discard all in-flight beats; first edge after deassertion operates as an empty pipe.

Configuration
REQ-026 Macro DFF_PIPE_FLUSH_EN defined: flush port exists; flush=1 at an edge SHALL clear all vld[] (data held), override any load that cycle, force in_ready=0 that cycle, count=0 next cycle.
REQ-027 Macro DFF_PIPE_FLUSH_EN undefined: flush port absent; no flush logic; all other behaviour identical.

Structure
REQ-028 Package dff_pipe_pkg SHALL hold default WIDTH/DEPTH constants and the count-width function.
REQ-029 One sub-module dff_pipe_stage (one valid+data register with async active-low reset and load enable) SHALL be instantiated DEPTH times via generate.

Verification
REQ-030 Reset: rstn=0 for 2 cycles with in_valid=1, in_data=8'hA5 -> out_valid=0, count=0, out_data=0 throughout.
REQ-031 Streaming: DEPTH=4, out_ready=1, inputs 8'h01..8'h08 back-to-back -> out_data 8'h01..8'h08 in order, first out_valid exactly 4 cycles after first handshake, no gaps.
REQ-032 Backpressure: out_ready=0, push 5 beats -> 4 accepted, in_ready=0, count=4; raise out_ready for 1 cycle -> 8'h01 out, 5th beat accepted same cycle, count stays 4.
REQ-033 Bubble collapse: push beat, idle 2 cycles, push beat, out_ready=0 -> both beats occupy stages 3 and 2, count=2.
REQ-034 Reset mid-operation: count=3, pulse rstn=0 between edges -> out_valid and count drop to 0 immediately, no stale beat after release.
REQ-035 Flush (DFF_PIPE_FLUSH_EN): count=4, flush=1 with in_valid=1 -> next cycle count=0, the offered beat not accepted, out_valid=0.
